// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage access controller.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } memState_e;

  // Read data substituted when a load is abandoned by the timeout.
  localparam logic [31:0] MEM_ERR_DATA  = 32'hDEAD_BEEF;
  localparam int          TIMEOUT_CNT_W = 16;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter for the memory access timeout (used only with MEM_ACCESS_TIMEOUT_EN).
module mem_timeout_ctr
  import mem_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     enable_i,
  input  logic [TIMEOUT_CNT_W-1:0] limit_i,
  output logic                     expired_o
);

  logic [TIMEOUT_CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      count <= '0;
    end else if (enable_i) begin
      count <= count + 1'b1;
    end
  end

  // Fires in the wait cycle that would bring the count up to the limit.
  assign expired_o = enable_i && (count == limit_i - 1'b1);

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store controller: req/ack handshake with pipeline stall.
// Optional timeout abort is enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [DATA_W-1:0] ALUResult_i,
  input  logic [DATA_W-1:0] WrData_i,
  output logic [DATA_W-1:0] ALUResult_o,
  output logic [DATA_W-1:0] RDData_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_err_o
);

  memState_e state;
  logic      memReq;
  logic      timeoutHit;

  assign memReq      = MemRead_i | MemWrite_i;
  assign ALUResult_o = ALUResult_i;
  // Stall rises in the request's own IDLE cycle so EX/MEM freezes immediately.
  assign stall_o     = (state == BUSY) || ((state == IDLE) && memReq);

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic ctrClear;
  logic ctrEnable;

  assign ctrClear  = (state == IDLE) && memReq;
  assign ctrEnable = (state == BUSY) && !mem_ack_i;

  mem_timeout_ctr u_timeoutCtr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (ctrClear),
    .enable_i  (ctrEnable),
    .limit_i   (TIMEOUT_CNT_W'(TIMEOUT_CYCLES)),
    .expired_o (timeoutHit)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_err_o <= 1'b0;
    end else if (timeoutHit) begin
      mem_err_o <= 1'b1;
    end
  end
`else
  assign timeoutHit = 1'b0;
  assign mem_err_o  = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      RDData_o    <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memReq) begin
            // A simultaneous read and write is treated as a write.
            mem_we_o    <= MemWrite_i;
            mem_addr_o  <= ALUResult_i;
            mem_wdata_o <= WrData_i;
            mem_req_o   <= 1'b1;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            if (!mem_we_o) RDData_o <= mem_rdata_i;
            mem_req_o <= 1'b0;
            state     <= DONE;
          end else if (timeoutHit) begin
            if (!mem_we_o) RDData_o <= DATA_W'(MEM_ERR_DATA);
            mem_req_o <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          // Inputs here still belong to the finished instruction.
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access controller between the EX/MEM pipeline register and the MEM/WB pipeline register. Turns a load/store into a request/acknowledge transaction on a variable-latency data memory and stalls the pipeline until the access completes. Presents read data (`RDData_o`) and the pass-through ALU result (`ALUResult_o`) to MEM/WB, which captures them on the same edge the stall releases.

## Interface
- `DATA_W`, 32, data and address width.
- `TIMEOUT_CYCLES`, 255, maximum BUSY cycles before abort. Used only with `MEM_ACCESS_TIMEOUT_EN`. Range 1..65535.
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `MemRead_i` in 1: load request from EX/MEM.
- `MemWrite_i` in 1: store request from EX/MEM.
- `ALUResult_i` in DATA_W: effective address or ALU result.
- `WrData_i` in DATA_W: store data.
- `ALUResult_o` out DATA_W: combinational copy of `ALUResult_i` to MEM/WB.
- `RDData_o` out DATA_W: registered load data to MEM/WB.
- `stall_o` out 1: freezes PC, IF/ID, ID/EX and EX/MEM when high.
- `mem_req_o` out 1: memory request.
- `mem_we_o` out 1: 1 = write.
- `mem_addr_o` out DATA_W: memory address.
- `mem_wdata_o` out DATA_W: memory write data.
- `mem_ack_i` in 1: memory completion, one-cycle pulse.
- `mem_rdata_i` in DATA_W: read data, valid with `mem_ack_i`.
- `mem_err_o` out 1: sticky timeout flag.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - If `MemRead_i | MemWrite_i`: latch address, write data and we; go to BUSY.
  - `stall_o` is asserted combinationally in this same cycle.
  - If both are set, treat as a write; no read data is captured.
  - If neither is set: stay in IDLE, `stall_o` = 0, pure pass-through.
- **BUSY**
  - `mem_req_o` = 1.
  - `mem_we_o`, `mem_addr_o`, `mem_wdata_o` driven from the latched registers and held stable until ack.
  - `stall_o` = 1.
  - On `mem_ack_i`: if read, capture `mem_rdata_i` into `RDData_o`; go to DONE.
- **DONE**
  - `stall_o` = 0, `mem_req_o` = 0.
  - Request inputs are ignored: they still belong to the completed instruction.
  - Always go to IDLE next cycle.
- `mem_ack_i` is ignored outside BUSY.
- `RDData_o` holds its last value across non-load instructions and writes.
- Reset values:
  - State = IDLE.
  - `RDData_o` = 0, `mem_req_o` = 0, `mem_we_o` = 0.
  - `mem_addr_o` = 0, `mem_wdata_o` = 0, `mem_err_o` = 0.
  - `stall_o` = 0 unless a request is present in that cycle.
- Reset mid-transaction: abort at the reset edge, drop `mem_req_o`, no capture. The memory must tolerate an abandoned request.

## Timing
- Minimum access, ack in the first BUSY cycle: 3 cycles (IDLE→BUSY→DONE), `stall_o` high for 2 cycles.
- Each extra wait cycle adds one stall cycle.
- `RDData_o` is valid throughout DONE; MEM/WB captures it at the end of DONE.
- `ALUResult_o` has zero latency and is stable during the stall because EX/MEM is frozen.
- Back-to-back memory instructions: DONE→IDLE→BUSY. There is no bubble beyond DONE.

## Configuration
- Macro: `MEM_ACCESS_TIMEOUT_EN`.
- **Defined**
  - A counter clears on BUSY entry and increments each BUSY cycle without ack.
  - At count = `TIMEOUT_CYCLES`: drop the request and go to DONE.
  - For a read, `RDData_o` = 32'hDEAD_BEEF.
  - `mem_err_o` is set and stays set until reset.
  - Ack in the same cycle the limit is reached takes priority: normal completion, no error.
- **Undefined**
  - BUSY waits indefinitely.
  - `mem_err_o` tied 0 and the counter is not instantiated.

## Structure
- Shared package `mem_pkg`: state enum (IDLE/BUSY/DONE) and constant `MEM_ERR_DATA` = 32'hDEAD_BEEF.
- One sub-module, `mem_timeout_ctr`: clear, enable, limit in; expired out.
  - Instantiated only under `MEM_ACCESS_TIMEOUT_EN`.

## Test plan
- **Load, zero-wait:** `MemRead_i` = 1, addr 0x40, ack with 0x1234_5678 in the first BUSY cycle.
  - Expect stall for exactly 2 cycles and `RDData_o` = 0x1234_5678 in DONE.
- **Store, 4 wait cycles:** addr 0x80, data 0xCAFE_F00D.
  - Expect `mem_req_o` / `mem_we_o` / addr / data held stable for 5 cycles, stall for 6 cycles, and `RDData_o` unchanged.
- **Back-to-back load then load:**
  - Expect the second request issued from IDLE the cycle after DONE, with no re-issue of the first load.
- **Non-memory instruction:**
  - Expect `stall_o` = 0 and `ALUResult_o` equal to `ALUResult_i` in the same cycle.
- **Reset in the second BUSY cycle:**
  - Expect state IDLE, `mem_req_o` = 0, `RDData_o` = 0 after the edge; a late ack is ignored.
- **With `MEM_ACCESS_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 8, no ack on a load:**
  - Expect DONE after 8 BUSY cycles, `RDData_o` = 0xDEAD_BEEF, and `mem_err_o` sticky until reset.
